run_monitor: RTL

- Synthesizable processor run monitor: watches the fetched instruction stream, counts cycles and retired instructions, detects a configurable halt sentinel, drains a fixed number of cycles, then flags completion.
- Generalises the halt-on-sentinel bench logic into reusable RTL with timeout, multiple sentinels and an optional PC history buffer.
- Sits beside the Processor top and taps its instruction word and PC; used by benches and by the on-board debug path.

---
 rtl/run_monitor_pkg.sv | 15 +
 rtl/run_monitor_if.sv | 13 +
 rtl/pc_history_buf.sv | 40 ++++
 rtl/run_monitor.sv | 121 ++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// rtl/run_monitor_pkg.sv - shared state encoding and constants for the run monitor
package run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_TMO   = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000DEAD;
  localparam int          DRAIN_BITS        = 8;

endpackage

// File: rtl/run_monitor_if.sv
// rtl/run_monitor_if.sv - fetched instruction tap (valid, word, pc) between processor and monitor
interface run_monitor_if #(
  parameter int DBITS = 32
);

  logic             inst_valid;
  logic [DBITS-1:0] inst_word;
  logic [DBITS-1:0] pc;

  modport master (output inst_valid, inst_word, pc);
  modport slave  (input  inst_valid, inst_word, pc);

endinterface

// File: rtl/pc_history_buf.sv
// rtl/pc_history_buf.sv - circular PC history with newest-first combinational read
// Only instantiated when RUN_MONITOR_PC_HIST_EN is defined.
module pc_history_buf
  import run_monitor_pkg::*;
#(
  parameter int  DBITS = 32,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [DBITS-1:0] rd_data
);

  logic [DBITS-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rd_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + 1'b1;
    end
  end

  // DEPTH is a power of two, so the AW-bit subtraction wraps modulo DEPTH.
  assign rd_addr = wptr - 1'b1 - rd_idx;
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - cycle/instruction counting run monitor with halt sentinel, drain and timeout
// Optional PC history buffer enabled by defining RUN_MONITOR_PC_HIST_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int               DBITS          = 32,
  parameter logic [DBITS-1:0] HALT_WORD      = DBITS'(DEFAULT_HALT_WORD),
  parameter logic [DBITS-1:0] HALT_WORD_ALT  = '1,
  parameter int               DRAIN_CYCLES   = 2,
  parameter int               CNT_BITS       = 32,
  parameter int               TIMEOUT_CYCLES = 0,
  parameter int               HIST_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  run_monitor_if.slave                  mon,
  output logic                          running,
  output logic                          done,
  output logic                          timed_out,
  output logic [DBITS-1:0]              halt_pc,
  output logic [CNT_BITS-1:0]           cycle_count,
  output logic [CNT_BITS-1:0]           inst_count,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [DBITS-1:0]              hist_pc
);

  localparam logic [DRAIN_BITS-1:0] DRAIN_LOAD = DRAIN_BITS'(DRAIN_CYCLES);
  localparam logic [CNT_BITS-1:0]   TMO_LAST   = CNT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [DRAIN_BITS-1:0] drain_cnt;
  logic                  sentinel;
  logic                  clr, cnt_en, inst_inc, halt_hit;

  // When HALT_WORD_ALT equals HALT_WORD the second compare is redundant, which disables it.
  assign sentinel = mon.inst_valid &&
                    ((mon.inst_word == HALT_WORD) || (mon.inst_word == HALT_WORD_ALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    cnt_en    = 1'b0;
    inst_inc  = 1'b0;
    halt_hit  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_TMO: begin
        if (start) begin
          state_nxt = ST_RUN;
          clr       = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (sentinel) begin
          // A sentinel on the timeout cycle takes priority over the timeout.
          halt_hit  = 1'b1;
          state_nxt = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          inst_inc = mon.inst_valid;
          if ((TIMEOUT_CYCLES != 0) && (cycle_count == TMO_LAST)) state_nxt = ST_TMO;
        end
      end
      ST_DRAIN: begin
        cnt_en = 1'b1;
        if (drain_cnt <= DRAIN_BITS'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      inst_count  <= '0;
      halt_pc     <= '0;
      drain_cnt   <= '0;
    end else begin
      if (clr) begin
        cycle_count <= '0;
        inst_count  <= '0;
        halt_pc     <= '0;
      end else begin
        if (cnt_en && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
        if (inst_inc && (inst_count != '1)) inst_count <= inst_count + 1'b1;
        if (halt_hit) halt_pc <= mon.pc;
      end
      if (halt_hit)                drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN) drain_cnt <= drain_cnt - 1'b1;
    end
  end

  assign running   = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign timed_out = (state == ST_TMO);

`ifdef RUN_MONITOR_PC_HIST_EN
  pc_history_buf #(
    .DBITS (DBITS),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .wr_en   ((state == ST_RUN) && mon.inst_valid),
    .wr_data (mon.pc),
    .rd_idx  (hist_idx),
    .rd_data (hist_pc)
  );
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_pc         = '0;
`endif

endmodule
